// File: rtl/tdc_test_pkg.sv
// Package: tdc_test_pkg
// Shared definitions for the TDC bench pulse generator.
//  - state_t / ST_*  : run-control FSM encoding (IDLE -> RUN -> FIN -> IDLE)
//  - MIN_PERIOD      : shortest period the counter supports; smaller requests are raised to it
package tdc_test_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/pulse_window.sv
// Module: pulse_window
// One output channel of pulse_pattern_gen. It holds the channel delay latched at run
// start, compares the shared period counter against [delay, delay+width], and
// registers the result onto the channel output.
// Ports:
//  clk_i    in   1       clock, rising edge
//  reset_i  in   1       synchronous, active-high
//  load_i   in   1       capture delay_i (run start)
//  delay_i  in   CNT_W   channel delay, sampled when load_i is high
//  width_i  in   WID_W   latched pulse width (pulse lasts width+1 cycles)
//  cnt_i    in   CNT_W   position inside the current period
//  en_i     in   1       window may drive the output this cycle
//  pulse_o  out  1       registered pulse
module pulse_window #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WID_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [WID_W-1:0] width_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             en_i,
  output logic             pulse_o
);

  logic [CNT_W-1:0] delay_q, delay_d;
  logic             pulse_q, pulse_d;

  // One extra bit so delay+width never wraps back into the low counter range.
  logic [CNT_W:0]   win_lo, win_hi, cnt_ext;

  always_comb begin
    delay_d = load_i ? delay_i : delay_q;
    win_lo  = {1'b0, delay_q};
    win_hi  = win_lo + {{(CNT_W + 1 - WID_W){1'b0}}, width_i};
    cnt_ext = {1'b0, cnt_i};
    // cnt never exceeds P-1, so the window is naturally cut at the period end and a
    // delay at or beyond P never matches.
    pulse_d = en_i && (cnt_ext >= win_lo) && (cnt_ext <= win_hi);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      delay_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      delay_q <= delay_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pulse_pattern_gen.sv
// Module: pulse_pattern_gen
// Multi-channel pulse generator for TDC bench testing. Every period of P cycles each
// channel emits one pulse at its own delay and the shared width. Runs a burst of
// burst_len periods, or free-runs (burst_len = 0) until stopped.
// Ports:
//  clk_i        in   1              clock, rising edge
//  reset_i      in   1              synchronous, active-high
//  start_i      in   1              strobe: latch config and begin a run (IDLE only)
//  stop_i       in   1              strobe: abort the run; wins over start in IDLE
//  period_i     in   CNT_W          cycles per period, values below 2 act as 2
//  delay_i      in   NUM_CH*CNT_W   channel i delay in delay_i[i*CNT_W +: CNT_W]
//  width_i      in   WID_W          pulse length is width+1 cycles
//  burst_len_i  in   BURST_W        periods per run, 0 = continuous
//  pulse_o      out  NUM_CH         registered channel pulses
//  sync_o       out  1              marks the cycle whose pulses reflect cnt == 0
//  busy_o       out  1              run in progress
//  done_o       out  1              one-cycle strobe at burst end or abort
module pulse_pattern_gen
  import tdc_test_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned WID_W   = 4,
  parameter int unsigned BURST_W = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [CNT_W-1:0]        period_i,
  input  logic [NUM_CH*CNT_W-1:0] delay_i,
  input  logic [WID_W-1:0]        width_i,
  input  logic [BURST_W-1:0]      burst_len_i,
  output logic [NUM_CH-1:0]       pulse_o,
  output logic                    sync_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(MIN_PERIOD);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [WID_W-1:0]   width_q, width_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] prd_q, prd_d;
  logic               sync_q, sync_d;

  logic               start_ok;
  logic               run_en;
  logic               last_cnt;
  logic               last_prd;
  logic [CNT_W-1:0]   period_clamped;

  always_comb begin
    start_ok       = (state_q == ST_IDLE) && start_i && !stop_i;
    // Channels may only drive during RUN; a stop forces them low on the next edge.
    run_en         = (state_q == ST_RUN) && !stop_i;
    period_clamped = (period_i < MinPeriod) ? MinPeriod : period_i;
    last_cnt       = (cnt_q == (period_q - CNT_W'(1)));
    last_prd       = (burst_q != '0) && (prd_q == (burst_q - BURST_W'(1)));
    sync_d         = run_en && (cnt_q == '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prd_d    = prd_q;
    period_d = period_q;
    width_d  = width_q;
    burst_d  = burst_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          prd_d    = '0;
          period_d = period_clamped;
          width_d  = width_i;
          burst_d  = burst_len_i;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_FIN;
        end else if (last_cnt) begin
          cnt_d = '0;
          prd_d = prd_q + BURST_W'(1);
          // The final period's pulses were already registered at this edge.
          if (last_prd) begin
            state_d = ST_FIN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prd_q    <= '0;
      period_q <= '0;
      width_q  <= '0;
      burst_q  <= '0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prd_q    <= prd_d;
      period_q <= period_d;
      width_q  <= width_d;
      burst_q  <= burst_d;
      sync_q   <= sync_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_window #(
      .CNT_W (CNT_W),
      .WID_W (WID_W)
    ) u_win (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (start_ok),
      .delay_i (delay_i[g*CNT_W +: CNT_W]),
      .width_i (width_q),
      .cnt_i   (cnt_q),
      .en_i    (run_en),
      .pulse_o (pulse_o[g])
    );
  end

  assign sync_o = sync_q;
  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_FIN);

endmodule
